repl_policy_unit: RTL and testbench

// Parametrised per-set replacement-policy engine for the set-associative L1 caches. Keeps a WAY_W-bit
// age per way per set (0 = next victim, WAYS-1 = youngest). Serves hit/fill/replace/demote requests

---
 rtl/repl_policy_unit.sv | 250 +++++++++++++++++++++++++
 tb/tb_repl_policy_unit.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/repl_policy_unit.sv
// rtl/repl_policy_unit.sv - per-set cache replacement-policy engine (LRU / FIFO / LFSR-random)
//
// Purpose:
//   Keeps a WAY_W-bit age for every way of every set (0 = next victim,
//   WAYS-1 = youngest) and serves HIT / FILL / REPLACE / DEMOTE requests
//   from the L1 cache controller over a start/done handshake. REPLACE
//   prefers the lowest invalid way, otherwise picks the oldest way (LRU and
//   FIFO) or a pseudo-random way taken from a 16-bit LFSR (RANDOM).
//
// Ports:
//   clk          in   1      clock, all state on posedge
//   rst          in   1      asynchronous active-high reset
//   start        in   1      request strobe, only sampled in IDLE
//   op           in   2      00=HIT 01=FILL 10=REPLACE 11=DEMOTE
//   index        in   SET_W  target set
//   way_index    in   WAY_W  target way for HIT/FILL/DEMOTE
//   valid_mask   in   WAYS   per-way valid bits of the set (REPLACE only)
//   busy         out  1      request in progress
//   done         out  1      one-cycle completion pulse
//   victim_index out  WAY_W  selected way, valid with done, held afterwards
//   victim_inv   out  1      with done: victim was an invalid way

module repl_policy_unit #(
  parameter int          WAYS      = 4,
  parameter int          SETS      = 512,
  parameter int          POLICY    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  localparam int         WAY_W     = $clog2(WAYS),
  localparam int         SET_W     = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [SET_W-1:0] index,
  input  logic [WAY_W-1:0] way_index,
  input  logic [WAYS-1:0]  valid_mask,
  output logic             busy,
  output logic             done,
  output logic [WAY_W-1:0] victim_index,
  output logic             victim_inv
);

  localparam logic [1:0] OP_HIT     = 2'b00;
  localparam logic [1:0] OP_FILL    = 2'b01;
  localparam logic [1:0] OP_REPLACE = 2'b10;
  localparam logic [1:0] OP_DEMOTE  = 2'b11;

  localparam logic [WAY_W-1:0] AGE_YOUNG = WAY_W'(WAYS - 1);
  localparam logic [WAY_W-1:0] AGE_OLD   = '0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Age storage: one single-entry write port per cycle.
  logic [WAY_W-1:0] age_q [SETS][WAYS];

  state_t           state_q,  state_d;
  logic [1:0]       op_q,     op_d;
  logic [SET_W-1:0] set_q,    set_d;
  logic [WAY_W-1:0] way_q,    way_d;
  logic [WAY_W-1:0] ref_q,    ref_d;
  logic             inv_q,    inv_d;
  logic [WAY_W-1:0] scan_q,   scan_d;
  logic [15:0]      lfsr_q,   lfsr_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;
  logic [WAY_W-1:0] victim_q, victim_d;
  logic             vinv_q,   vinv_d;

  logic             age_we;
  logic [SET_W-1:0] age_wr_set;
  logic [WAY_W-1:0] age_wr_way;
  logic [WAY_W-1:0] age_wr_val;

  logic [WAY_W-1:0] tgt_way;
  logic             tgt_inv;
  logic [WAY_W-1:0] cur_age;
  logic             touch_op;
  logic             demote_op;

  assign busy         = busy_q;
  assign done         = done_q;
  assign victim_index = victim_q;
  assign victim_inv   = vinv_q;

  // Target way chosen at accept time from the live request inputs.
  always_comb begin
    tgt_way = way_index;
    tgt_inv = 1'b0;
    if (op == OP_REPLACE) begin
      if (~&valid_mask) begin
        // Walk downward so the lowest invalid way wins.
        for (int j = WAYS - 1; j >= 0; j--) begin
          if (!valid_mask[j]) begin
            tgt_way = WAY_W'(j);
          end
        end
        tgt_inv = 1'b1;
      end else if (POLICY == 2) begin
        tgt_way = lfsr_q[WAY_W-1:0];
      end else begin
        // Ages form a permutation, so exactly one way is at age 0.
        for (int j = 0; j < WAYS; j++) begin
          if (age_q[index][j] == AGE_OLD) begin
            tgt_way = WAY_W'(j);
          end
        end
      end
    end
  end

  // Which age transformation the latched op performs under this policy.
  always_comb begin
    touch_op  = 1'b0;
    demote_op = 1'b0;
    case (op_q)
      OP_HIT:     touch_op  = (POLICY == 0);
      OP_FILL:    touch_op  = (POLICY != 2);
      OP_REPLACE: touch_op  = (POLICY != 2);
      OP_DEMOTE:  demote_op = 1'b1;
      default:    touch_op  = 1'b0;
    endcase
  end

  assign cur_age = age_q[set_q][scan_q];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    set_d      = set_q;
    way_d      = way_q;
    ref_d      = ref_q;
    inv_d      = inv_q;
    scan_d     = scan_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    victim_d   = victim_q;
    vinv_d     = vinv_q;
    age_we     = 1'b0;
    age_wr_set = set_q;
    age_wr_way = scan_q;
    age_wr_val = cur_age;
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SCAN;
          busy_d  = 1'b1;
          vinv_d  = 1'b0;
          op_d    = op;
          set_d   = index;
          way_d   = tgt_way;
          ref_d   = age_q[index][tgt_way];
          inv_d   = tgt_inv;
          scan_d  = '0;
        end
      end

      S_SCAN: begin
        // The target way's own age equals ref, so the generic compare never
        // moves it; its final age is written when the scan reaches it, which
        // keeps the write port to one entry per cycle.
        if (touch_op) begin
          if (scan_q == way_q) begin
            age_we     = 1'b1;
            age_wr_val = AGE_YOUNG;
          end else if (cur_age > ref_q) begin
            age_we     = 1'b1;
            age_wr_val = cur_age - WAY_W'(1);
          end
        end else if (demote_op) begin
          if (scan_q == way_q) begin
            age_we     = 1'b1;
            age_wr_val = AGE_OLD;
          end else if (cur_age < ref_q) begin
            age_we     = 1'b1;
            age_wr_val = cur_age + WAY_W'(1);
          end
        end
        scan_d = scan_q + WAY_W'(1);
        if (scan_q == AGE_YOUNG) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        state_d  = S_IDLE;
        busy_d   = 1'b0;
        done_d   = 1'b1;
        victim_d = way_q;
        vinv_d   = inv_q;
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_HIT;
      set_q    <= '0;
      way_q    <= '0;
      ref_q    <= '0;
      inv_q    <= 1'b0;
      scan_q   <= '0;
      lfsr_q   <= LFSR_SEED;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      victim_q <= '0;
      vinv_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      set_q    <= set_d;
      way_q    <= way_d;
      ref_q    <= ref_d;
      inv_q    <= inv_d;
      scan_q   <= scan_d;
      lfsr_q   <= lfsr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      victim_q <= victim_d;
      vinv_q   <= vinv_d;
    end
  end

  // Every set restarts as the identity permutation; a reset mid-scan
  // therefore discards any partially applied update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < SETS; s++) begin
        for (int w = 0; w < WAYS; w++) begin
          age_q[s][w] <= WAY_W'(w);
        end
      end
    end else if (age_we) begin
      age_q[age_wr_set][age_wr_way] <= age_wr_val;
    end
  end

endmodule

// File: tb/tb_repl_policy_unit.sv
// tb/tb_repl_policy_unit.sv - scoreboard bench running LRU, FIFO and RANDOM instances side by side

module tb_repl_policy_unit;

  localparam int WAYS  = 4;
  localparam int SETS  = 16;
  localparam int WAY_W = 2;
  localparam int SET_W = 4;

  localparam logic [1:0] OP_HIT     = 2'b00;
  localparam logic [1:0] OP_FILL    = 2'b01;
  localparam logic [1:0] OP_REPLACE = 2'b10;
  localparam logic [1:0] OP_DEMOTE  = 2'b11;

  logic             clk = 1'b0;
  logic             rst;
  logic             start;
  logic [1:0]       op;
  logic [SET_W-1:0] index;
  logic [WAY_W-1:0] way_index;
  logic [WAYS-1:0]  valid_mask;
  logic [2:0]       busy_v;
  logic [2:0]       done_v;
  logic [2:0]       inv_v;
  logic [WAY_W-1:0] vic_v [3];

  int errors = 0;
  int checks = 0;

  typedef struct {
    int         p;
    logic [1:0] vic;
    logic       inv;
  } exp_t;

  exp_t        sb [$];
  int          mdl [3][SETS][WAYS];
  logic [15:0] lfsr_m;

  always #5 clk = ~clk;

  repl_policy_unit #(.WAYS(WAYS), .SETS(SETS), .POLICY(0), .LFSR_SEED(16'hACE1)) u0 (
    .clk(clk), .rst(rst), .start(start), .op(op), .index(index), .way_index(way_index),
    .valid_mask(valid_mask), .busy(busy_v[0]), .done(done_v[0]), .victim_index(vic_v[0]),
    .victim_inv(inv_v[0]));

  repl_policy_unit #(.WAYS(WAYS), .SETS(SETS), .POLICY(1), .LFSR_SEED(16'hACE1)) u1 (
    .clk(clk), .rst(rst), .start(start), .op(op), .index(index), .way_index(way_index),
    .valid_mask(valid_mask), .busy(busy_v[1]), .done(done_v[1]), .victim_index(vic_v[1]),
    .victim_inv(inv_v[1]));

  repl_policy_unit #(.WAYS(WAYS), .SETS(SETS), .POLICY(2), .LFSR_SEED(16'hACE1)) u2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .index(index), .way_index(way_index),
    .valid_mask(valid_mask), .busy(busy_v[2]), .done(done_v[2]), .victim_index(vic_v[2]),
    .victim_inv(inv_v[2]));

  // Reference LFSR: x^16+x^14+x^13+x^11+1, one step per clock out of reset.
  always @(posedge clk or posedge rst) begin
    if (rst) lfsr_m <= 16'hACE1;
    else     lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int dut_age(input int p, input int s, input int j);
    case (p)
      0:       return int'(u0.age_q[s][j]);
      1:       return int'(u1.age_q[s][j]);
      default: return int'(u2.age_q[s][j]);
    endcase
  endfunction

  function automatic void model_reset();
    for (int p = 0; p < 3; p++)
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          mdl[p][s][w] = w;
  endfunction

  task automatic check_set(input string tag, input int s);
    for (int p = 0; p < 3; p++) begin
      logic [3:0] seen;
      seen = '0;
      for (int j = 0; j < WAYS; j++) begin
        check($sformatf("%s age p%0d s%0d w%0d", tag, p, s, j), dut_age(p, s, j), mdl[p][s][j]);
        seen[dut_age(p, s, j) & 3] = 1'b1;
      end
      check($sformatf("%s perm p%0d s%0d", tag, p, s), seen, 4'hF);
    end
  endtask

  // Issue one request to all three instances, predict each outcome from the
  // model, and compare when done arrives. glitch pulses start mid-scan;
  // b2b returns right after done so the next request lands at the earliest edge.
  task automatic do_op(input string tag, input logic [1:0] o, input int s, input int w,
                       input logic [3:0] m, input bit glitch, input bit b2b);
    int tw, r, lat, extra;
    bit tinv, touch;
    for (int p = 0; p < 3; p++) begin
      tw = w;
      tinv = 1'b0;
      if (o == OP_REPLACE) begin
        if (m != 4'hF) begin
          for (int j = WAYS - 1; j >= 0; j--) if (!m[j]) tw = j;
          tinv = 1'b1;
        end else if (p == 2) begin
          tw = int'(lfsr_m[1:0]);
        end else begin
          for (int j = 0; j < WAYS; j++) if (mdl[p][s][j] == 0) tw = j;
        end
      end
      r = mdl[p][s][tw];
      touch = (o == OP_HIT && p == 0) || ((o == OP_FILL || o == OP_REPLACE) && p != 2);
      if (touch) begin
        for (int j = 0; j < WAYS; j++) if (j != tw && mdl[p][s][j] > r) mdl[p][s][j]--;
        mdl[p][s][tw] = WAYS - 1;
      end else if (o == OP_DEMOTE) begin
        for (int j = 0; j < WAYS; j++) if (j != tw && mdl[p][s][j] < r) mdl[p][s][j]++;
        mdl[p][s][tw] = 0;
      end
      sb.push_back('{p: p, vic: tw[1:0], inv: tinv});
    end

    start      = 1'b1;
    op         = o;
    index      = SET_W'(s);
    way_index  = WAY_W'(w);
    valid_mask = m;
    @(negedge clk);
    start = 1'b0;
    check({tag, " busy"}, busy_v, 3'b111);

    lat = 0;
    for (int n = 1; n <= 12; n++) begin
      if (glitch && n == 2) begin
        start     = 1'b1;
        op        = OP_DEMOTE;
        way_index = WAY_W'(w + 1);
      end
      if (glitch && n == 3) start = 1'b0;
      @(negedge clk);
      if (done_v != 3'b000) begin
        lat = n;
        break;
      end
    end
    check({tag, " latency"}, lat, WAYS + 1);
    check({tag, " done"}, done_v, 3'b111);
    check({tag, " busy@done"}, busy_v, 3'b000);

    for (int k = 0; k < 3; k++) begin
      exp_t e;
      if (sb.size() == 0) begin
        check({tag, " scoreboard"}, 0, 1);
        break;
      end
      e = sb.pop_front();
      check($sformatf("%s victim p%0d", tag, e.p), vic_v[e.p], e.vic);
      check($sformatf("%s victim_inv p%0d", tag, e.p), inv_v[e.p], e.inv);
    end
    check_set(tag, s);

    if (!b2b) begin
      @(negedge clk);
      check({tag, " done pulse"}, done_v, 3'b000);
      if (glitch) begin
        extra = 0;
        repeat (WAYS + 2) begin
          @(negedge clk);
          if (done_v != 3'b000) extra++;
        end
        check({tag, " no extra done"}, extra, 0);
      end
    end
  endtask

  initial begin
    int dones;
    rst        = 1'b1;
    start      = 1'b0;
    op         = OP_HIT;
    index      = '0;
    way_index  = '0;
    valid_mask = 4'hF;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;

    check("reset busy", busy_v, 3'b000);
    check("reset done", done_v, 3'b000);
    check("reset victim_inv", inv_v, 3'b000);
    for (int p = 0; p < 3; p++) check($sformatf("reset victim p%0d", p), vic_v[p], 2'd0);
    check_set("reset", 0);

    do_op("replace s0", OP_REPLACE, 0, 0, 4'hF, 1'b0, 1'b0);

    do_op("hit s5 w0", OP_HIT, 5, 0, 4'hF, 1'b0, 1'b0);
    do_op("replace s5", OP_REPLACE, 5, 0, 4'hF, 1'b0, 1'b0);
    check("lru s5 victim is way1", vic_v[0], 2'd1);
    do_op("replace s1", OP_REPLACE, 1, 0, 4'hF, 1'b0, 1'b0);
    check("lru s1 victim is way0", vic_v[0], 2'd0);

    do_op("replace inv", OP_REPLACE, 5, 0, 4'b1011, 1'b0, 1'b0);
    do_op("replace after inv", OP_REPLACE, 5, 0, 4'hF, 1'b0, 1'b0);

    do_op("hit s8 w0", OP_HIT, 8, 0, 4'hF, 1'b0, 1'b0);
    do_op("replace s8 a", OP_REPLACE, 8, 0, 4'hF, 1'b0, 1'b0);
    check("fifo s8 victim way0", vic_v[1], 2'd0);
    do_op("fill s8 w0", OP_FILL, 8, 0, 4'hF, 1'b0, 1'b0);
    do_op("replace s8 b", OP_REPLACE, 8, 0, 4'hF, 1'b0, 1'b0);
    check("fifo s8 victim way1", vic_v[1], 2'd1);

    do_op("demote s7 w3", OP_DEMOTE, 7, 3, 4'hF, 1'b0, 1'b0);
    do_op("replace s7", OP_REPLACE, 7, 0, 4'hF, 1'b0, 1'b0);
    check("lru s7 victim way3", vic_v[0], 2'd3);
    do_op("demote oldest", OP_DEMOTE, 9, 0, 4'hF, 1'b0, 1'b0);
    do_op("hit youngest", OP_HIT, 9, 3, 4'hF, 1'b0, 1'b0);

    do_op("glitch fill", OP_FILL, 10, 2, 4'hF, 1'b1, 1'b0);
    do_op("b2b a", OP_HIT, 11, 1, 4'hF, 1'b0, 1'b1);
    do_op("b2b b", OP_REPLACE, 11, 0, 4'hF, 1'b0, 1'b0);
    do_op("rand a", OP_REPLACE, 12, 0, 4'hF, 1'b0, 1'b0);
    do_op("rand b", OP_REPLACE, 12, 0, 4'hF, 1'b0, 1'b0);

    do_op("hit s3 w0", OP_HIT, 3, 0, 4'hF, 1'b0, 1'b0);
    start     = 1'b1;
    op        = OP_HIT;
    index     = SET_W'(3);
    way_index = WAY_W'(2);
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    repeat (2) begin
      @(negedge clk);
      if (done_v != 3'b000) dones++;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check("abort busy", busy_v, 3'b000);
    repeat (WAYS + 4) begin
      @(negedge clk);
      if (done_v != 3'b000) dones++;
    end
    check("abort no done", dones, 0);
    check_set("abort", 3);

    do_op("post-reset replace", OP_REPLACE, 3, 0, 4'hF, 1'b0, 1'b0);
    do_op("post-reset rand", OP_REPLACE, 4, 0, 4'hF, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
